// File: rtl/tournament_predictor_if.sv
// Prediction/update bus of the tournament branch predictor.
// master = fetch/resolve side, slave = predictor.
interface tournament_predictor_if #(
    parameter int N  = 32,
    parameter int S  = 10,
    parameter int H  = 10,
    parameter int CW = 32
) ();
    logic          pred_valid;
    logic [N-1:0]  pred_pc;
    logic [N-1:0]  pred_offset;
    logic          ready;
    logic          pred_out_valid;
    logic          prediction;
    logic [N-1:0]  next_pc;
    logic [H-1:0]  pred_ghr;
    logic          upd_valid;
    logic [N-1:0]  upd_pc;
    logic [H-1:0]  upd_ghr;
    logic          upd_taken;
    logic          upd_pred;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;

    modport master (
        output pred_valid, pred_pc, pred_offset,
        output upd_valid, upd_pc, upd_ghr, upd_taken, upd_pred,
        input  ready, pred_out_valid, prediction, next_pc, pred_ghr,
        input  hit_cnt, miss_cnt
    );

    modport slave (
        input  pred_valid, pred_pc, pred_offset,
        input  upd_valid, upd_pc, upd_ghr, upd_taken, upd_pred,
        output ready, pred_out_valid, prediction, next_pc, pred_ghr,
        output hit_cnt, miss_cnt
    );
endinterface

// File: rtl/tournament_predictor.sv
// Tournament branch predictor: bimodal + gshare PHTs with a chooser, 1-cycle registered prediction.
// Optional hit/miss performance counters are enabled by defining TOURNAMENT_PERF_CNT_EN.
module tournament_predictor #(
    parameter int N  = 32,
    parameter int S  = 10,
    parameter int H  = 10,
    parameter int CW = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    tournament_predictor_if.slave bp
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int           ENTRIES  = 2 ** S;
    localparam logic [1:0]   CTR_INIT = 2'b01;
    localparam logic [N-1:0] PC_STEP  = N'(3'd4);

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        sat_inc = (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        sat_dec = (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
        ctr_step = taken ? sat_inc(c) : sat_dec(c);
    endfunction

    function automatic logic [S-1:0] zext_ghr(input logic [H-1:0] g);
        zext_ghr = '0;
        zext_ghr[H-1:0] = g;
    endfunction

    state_e        state_q, state_d;
    logic [S-1:0]  sweep_q, sweep_d;
    logic [H-1:0]  ghr_q;
    logic          pred_out_valid_q;
    logic          prediction_q;
    logic [N-1:0]  next_pc_q;
    logic [H-1:0]  pred_ghr_q;

    logic [1:0]    bim_q [ENTRIES];
    logic [1:0]    gsh_q [ENTRIES];
    logic [1:0]    cho_q [ENTRIES];

    logic          run_s, pred_fire_s, upd_fire_s;
    logic [S-1:0]  pidx_b_s, pidx_g_s, uidx_b_s, uidx_g_s;
    logic [1:0]    p_bim_s, p_gsh_s, p_cho_s;
    logic [1:0]    u_bim_s, u_gsh_s, u_cho_s;
    logic [1:0]    bim_new_s, gsh_new_s, cho_new_s;
    logic          pred_taken_s;
    logic [N-1:0]  next_pc_s;

    assign run_s       = (state_q == ST_RUN);
    assign pred_fire_s = run_s & bp.pred_valid;
    assign upd_fire_s  = run_s & bp.upd_valid;

    assign pidx_b_s = bp.pred_pc[S+1:2];
    assign pidx_g_s = bp.pred_pc[S+1:2] ^ zext_ghr(ghr_q);
    assign uidx_b_s = bp.upd_pc[S+1:2];
    assign uidx_g_s = bp.upd_pc[S+1:2] ^ zext_ghr(bp.upd_ghr);

    // Table reads happen before the edge, so a same-cycle update is not visible to the prediction.
    assign p_bim_s = bim_q[pidx_b_s];
    assign p_gsh_s = gsh_q[pidx_g_s];
    assign p_cho_s = cho_q[pidx_b_s];
    assign u_bim_s = bim_q[uidx_b_s];
    assign u_gsh_s = gsh_q[uidx_g_s];
    assign u_cho_s = cho_q[uidx_b_s];

    // FSM state and init-sweep index register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Next state: sweep every entry once, then run
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + S'(1'b1);
                if (sweep_q == {S{1'b1}}) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
                sweep_d = '0;
            end
            default: begin
                state_d = ST_INIT;
                sweep_d = '0;
            end
        endcase
    end

    // Prediction select and target computation
    always_comb begin
        if (p_cho_s[1]) begin
            pred_taken_s = p_gsh_s[1];
        end else begin
            pred_taken_s = p_bim_s[1];
        end
        next_pc_s = bp.pred_pc + (pred_taken_s ? bp.pred_offset : PC_STEP);
    end

    // Counter training; chooser moves only when the two components disagreed
    always_comb begin
        bim_new_s = ctr_step(u_bim_s, bp.upd_taken);
        gsh_new_s = ctr_step(u_gsh_s, bp.upd_taken);
        cho_new_s = u_cho_s;
        if (u_bim_s[1] != u_gsh_s[1]) begin
            if (u_gsh_s[1] == bp.upd_taken) begin
                cho_new_s = sat_inc(u_cho_s);
            end else begin
                cho_new_s = sat_dec(u_cho_s);
            end
        end else begin
            cho_new_s = u_cho_s;
        end
    end

    // Counter tables: cleared by the sweep, no reset on the storage itself
    always_ff @(posedge clock) begin
        if (state_q == ST_INIT) begin
            bim_q[sweep_q] <= CTR_INIT;
            gsh_q[sweep_q] <= CTR_INIT;
            cho_q[sweep_q] <= CTR_INIT;
        end else if (upd_fire_s) begin
            bim_q[uidx_b_s] <= bim_new_s;
            gsh_q[uidx_g_s] <= gsh_new_s;
            cho_q[uidx_b_s] <= cho_new_s;
        end
    end

    // Global history and registered prediction outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ghr_q            <= '0;
            pred_out_valid_q <= 1'b0;
            prediction_q     <= 1'b0;
            next_pc_q        <= '0;
            pred_ghr_q       <= '0;
        end else begin
            pred_out_valid_q <= pred_fire_s;
            if (upd_fire_s) begin
                ghr_q <= {ghr_q[H-2:0], bp.upd_taken};
            end
            if (pred_fire_s) begin
                prediction_q <= pred_taken_s;
                next_pc_q    <= next_pc_s;
                pred_ghr_q   <= ghr_q;
            end
        end
    end

    assign bp.ready          = run_s;
    assign bp.pred_out_valid = pred_out_valid_q;
    assign bp.prediction     = prediction_q;
    assign bp.next_pc        = next_pc_q;
    assign bp.pred_ghr       = pred_ghr_q;

`ifdef TOURNAMENT_PERF_CNT_EN
    logic [CW-1:0] hit_q;
    logic [CW-1:0] miss_q;

    // Saturating hit/miss counters, counted only on accepted updates
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (upd_fire_s) begin
            if (bp.upd_pred == bp.upd_taken) begin
                if (hit_q != {CW{1'b1}}) begin
                    hit_q <= hit_q + CW'(1'b1);
                end
            end else begin
                if (miss_q != {CW{1'b1}}) begin
                    miss_q <= miss_q + CW'(1'b1);
                end
            end
        end
    end

    assign bp.hit_cnt  = hit_q;
    assign bp.miss_cnt = miss_q;
`else
    assign bp.hit_cnt  = '0;
    assign bp.miss_cnt = '0;
`endif

endmodule
